// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: control bit layout, bubble encoding and
// per-boundary data widths used when instantiating mips_pipe_reg.
package mips_pkg;

  localparam int CTRL_W_DEFAULT = 8;

  localparam int CTRL_REGWRITE  = 0;
  localparam int CTRL_MEMREAD   = 1;
  localparam int CTRL_MEMWRITE  = 2;
  localparam int CTRL_ALUOP_LSB = 3;
  localparam int CTRL_ALUOP_MSB = 4;

  // All write/read enables low: a bubble can never modify architectural state
  localparam logic [CTRL_W_DEFAULT-1:0] CTRL_NOP_DEFAULT = '0;

  localparam int IFID_DATA_W  = 64;
  localparam int IDEX_DATA_W  = 96;
  localparam int EXMEM_DATA_W = 72;
  localparam int MEMWB_DATA_W = 69;

  typedef enum logic [1:0] {
    BND_IFID,
    BND_IDEX,
    BND_EXMEM,
    BND_MEMWB
  } pipe_boundary_e;

  function automatic int boundary_data_w(pipe_boundary_e bnd);
    case (bnd)
      BND_IFID:  return IFID_DATA_W;
      BND_IDEX:  return IDEX_DATA_W;
      BND_EXMEM: return EXMEM_DATA_W;
      default:   return MEMWB_DATA_W;
    endcase
  endfunction

endpackage

// File: rtl/mips_pipe_reg_if.sv
// Stage-boundary bus: hazard controls and incoming instruction from the
// producer side, registered instruction and occupancy back out.
interface mips_pipe_reg_if #(
  parameter int CTRL_W = mips_pkg::CTRL_W_DEFAULT,
  parameter int DATA_W = mips_pkg::IDEX_DATA_W,
  parameter int DEPTH  = 1
);
  import mips_pkg::*;

  localparam int OCC_W = $clog2(DEPTH + 1);

  logic              stall;
  logic              flush;
  logic              in_valid;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [OCC_W-1:0]  occupancy;

  modport master (
    output stall, flush, in_valid, in_ctrl, in_data,
    input  out_valid, out_ctrl, out_data, occupancy
  );

  modport slave (
    input  stall, flush, in_valid, in_ctrl, in_data,
    output out_valid, out_ctrl, out_data, occupancy
  );

endinterface

// File: rtl/mips_pipe_stage.sv
// One pipeline register stage; clear turns it into a bubble, and a bubble
// always carries the NOP control encoding.
module mips_pipe_stage import mips_pkg::*; #(
  parameter int                CTRL_W   = CTRL_W_DEFAULT,
  parameter int                DATA_W   = IDEX_DATA_W,
  parameter logic [CTRL_W-1:0] CTRL_NOP = CTRL_W'(CTRL_NOP_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic              d_valid,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic              q_valid,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [DATA_W-1:0] q_data
);

  // Clear beats load; data is left alone on clear since a bubble's data is dead
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_valid <= 1'b0;
      q_ctrl  <= CTRL_NOP;
      q_data  <= '0;
    end else if (clear) begin
      q_valid <= 1'b0;
      q_ctrl  <= CTRL_NOP;
    end else if (load) begin
      q_valid <= d_valid;
      q_ctrl  <= d_valid ? d_ctrl : CTRL_NOP;
      q_data  <= d_data;
    end
  end

endmodule

// File: rtl/mips_pipe_reg.sv
// Inter-stage pipeline register of DEPTH chained stages with stall, flush
// and a registered count of in-flight valid instructions.
module mips_pipe_reg import mips_pkg::*; #(
  parameter int                CTRL_W   = CTRL_W_DEFAULT,
  parameter int                DATA_W   = IDEX_DATA_W,
  parameter int                DEPTH    = 1,
  parameter logic [CTRL_W-1:0] CTRL_NOP = CTRL_W'(CTRL_NOP_DEFAULT)
) (
  input logic            clk,
  input logic            rst_n,
  mips_pipe_reg_if.slave bus
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
    $error("mips_pipe_reg: DEPTH must be in 1..4");
  end

  logic [DEPTH-1:0]  stage_valid;
  logic [CTRL_W-1:0] stage_ctrl [DEPTH];
  logic [DATA_W-1:0] stage_data [DEPTH];
  logic [DEPTH-1:0]  adv_valid;
  logic [OCC_W-1:0]  occ_next;
  logic [OCC_W-1:0]  occ_q;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    if (g == 0) begin : g_head
      mips_pipe_stage #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CTRL_NOP(CTRL_NOP)) u_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (!bus.stall),
        .clear   (bus.flush),
        .d_valid (bus.in_valid),
        .d_ctrl  (bus.in_ctrl),
        .d_data  (bus.in_data),
        .q_valid (stage_valid[g]),
        .q_ctrl  (stage_ctrl[g]),
        .q_data  (stage_data[g])
      );
    end else begin : g_body
      mips_pipe_stage #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CTRL_NOP(CTRL_NOP)) u_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (!bus.stall),
        .clear   (bus.flush),
        .d_valid (stage_valid[g-1]),
        .d_ctrl  (stage_ctrl[g-1]),
        .d_data  (stage_data[g-1]),
        .q_valid (stage_valid[g]),
        .q_ctrl  (stage_ctrl[g]),
        .q_data  (stage_data[g])
      );
    end
  end

  // Valid bits the stages would hold after an advancing edge
  assign adv_valid = DEPTH'({stage_valid, bus.in_valid});

  always_comb begin
    occ_next = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ_next = occ_next + OCC_W'(adv_valid[k]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= '0;
    end else if (bus.flush) begin
      occ_q <= '0;
    end else if (!bus.stall) begin
      occ_q <= occ_next;
    end
  end

  assign bus.out_valid = stage_valid[DEPTH-1];
  assign bus.out_ctrl  = stage_valid[DEPTH-1] ? stage_ctrl[DEPTH-1] : CTRL_NOP;
  assign bus.out_data  = stage_data[DEPTH-1];
  assign bus.occupancy = occ_q;

endmodule

// File: tb/tb_mips_pipe_reg.sv
// Drives identical stimulus into DEPTH=1..4 instances and checks them against
// a stage-array reference model, a vector table and directed corner sequences.
module tb_mips_pipe_reg;
  import mips_pkg::*;

  logic clk;
  logic rst_n;
  int   testsRun    = 0;
  int   testsFailed = 0;

  mips_pipe_reg_if #(.CTRL_W(8), .DATA_W(96), .DEPTH(1)) bus1 ();
  mips_pipe_reg_if #(.CTRL_W(8), .DATA_W(96), .DEPTH(2)) bus2 ();
  mips_pipe_reg_if #(.CTRL_W(8), .DATA_W(96), .DEPTH(3)) bus3 ();
  mips_pipe_reg_if #(.CTRL_W(8), .DATA_W(96), .DEPTH(4)) bus4 ();

  mips_pipe_reg #(.CTRL_W(8), .DATA_W(96), .DEPTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  mips_pipe_reg #(.CTRL_W(8), .DATA_W(96), .DEPTH(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  mips_pipe_reg #(.CTRL_W(8), .DATA_W(96), .DEPTH(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));
  mips_pipe_reg #(.CTRL_W(8), .DATA_W(96), .DEPTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: per depth, an array of in-flight slots, slot 0 newest
  logic        mv [1:4][4];
  logic [7:0]  mc [1:4][4];
  logic [95:0] md [1:4][4];

  typedef struct {
    logic        s, f, iv;
    logic [7:0]  ic;
    logic [95:0] id;
    logic        ev;
    logic [7:0]  ec;
    logic [95:0] ed;
    int          eo;
  } vec_t;

  vec_t vecs [9];

  function automatic void check(string name, logic [95:0] act, logic [95:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  function automatic void modelReset();
    for (int d = 1; d <= 4; d++)
      for (int k = 0; k < 4; k++) begin
        mv[d][k] = 1'b0;
        mc[d][k] = 8'h00;
        md[d][k] = '0;
      end
  endfunction

  function automatic void modelStep(logic s, logic f, logic iv, logic [7:0] ic, logic [95:0] id);
    for (int d = 1; d <= 4; d++) begin
      if (f) begin
        for (int k = 0; k < d; k++) begin
          mv[d][k] = 1'b0;
          mc[d][k] = 8'h00;
        end
      end else if (!s) begin
        for (int k = d - 1; k > 0; k--) begin
          mv[d][k] = mv[d][k-1];
          mc[d][k] = mc[d][k-1];
          md[d][k] = md[d][k-1];
        end
        mv[d][0] = iv;
        mc[d][0] = iv ? ic : 8'h00;
        md[d][0] = id;
      end
    end
  endfunction

  function automatic int modelOcc(int d);
    int n = 0;
    for (int k = 0; k < d; k++) n += int'(mv[d][k]);
    return n;
  endfunction

  task automatic driveAll(input logic s, input logic f, input logic iv,
                          input logic [7:0] ic, input logic [95:0] id);
    bus1.stall = s; bus1.flush = f; bus1.in_valid = iv; bus1.in_ctrl = ic; bus1.in_data = id;
    bus2.stall = s; bus2.flush = f; bus2.in_valid = iv; bus2.in_ctrl = ic; bus2.in_data = id;
    bus3.stall = s; bus3.flush = f; bus3.in_valid = iv; bus3.in_ctrl = ic; bus3.in_data = id;
    bus4.stall = s; bus4.flush = f; bus4.in_valid = iv; bus4.in_ctrl = ic; bus4.in_data = id;
  endtask

  task automatic readDut(input int d, output logic v, output logic [7:0] c,
                         output logic [95:0] dt, output int o);
    case (d)
      1: begin v = bus1.out_valid; c = bus1.out_ctrl; dt = bus1.out_data; o = int'(bus1.occupancy); end
      2: begin v = bus2.out_valid; c = bus2.out_ctrl; dt = bus2.out_data; o = int'(bus2.occupancy); end
      3: begin v = bus3.out_valid; c = bus3.out_ctrl; dt = bus3.out_data; o = int'(bus3.occupancy); end
      default: begin v = bus4.out_valid; c = bus4.out_ctrl; dt = bus4.out_data; o = int'(bus4.occupancy); end
    endcase
  endtask

  // Drive at the falling edge, let one rising edge happen, return at the next falling edge
  task automatic applyStimulus(input logic s, input logic f, input logic iv,
                               input logic [7:0] ic, input logic [95:0] id);
    driveAll(s, f, iv, ic, id);
    @(posedge clk);
    modelStep(s, f, iv, ic, id);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag);
    logic v; logic [7:0] c; logic [95:0] dt; int o; logic ev;
    for (int d = 1; d <= 4; d++) begin
      readDut(d, v, c, dt, o);
      ev = mv[d][d-1];
      check($sformatf("%s d%0d valid", tag, d), 96'(v), 96'(ev));
      check($sformatf("%s d%0d ctrl", tag, d), 96'(c), ev ? 96'(mc[d][d-1]) : 96'h0);
      check($sformatf("%s d%0d occ", tag, d), 96'(o), 96'(modelOcc(d)));
      if (ev) check($sformatf("%s d%0d data", tag, d), dt, md[d][d-1]);
    end
  endtask

  task automatic cycle(input string tag, input logic s, input logic f, input logic iv,
                       input logic [7:0] ic, input logic [95:0] id);
    applyStimulus(s, f, iv, ic, id);
    checkOutput(tag);
  endtask

  task automatic checkAllReset(input string tag);
    logic v; logic [7:0] c; logic [95:0] dt; int o;
    for (int d = 1; d <= 4; d++) begin
      readDut(d, v, c, dt, o);
      check($sformatf("%s d%0d valid", tag, d), 96'(v), 96'h0);
      check($sformatf("%s d%0d ctrl", tag, d), 96'(c), 96'h0);
      check($sformatf("%s d%0d data", tag, d), dt, 96'h0);
      check($sformatf("%s d%0d occ", tag, d), 96'(o), 96'h0);
    end
  endtask

  initial begin
    logic v; logic [7:0] c; logic [95:0] dt; int o;
    int nextExp;

    // Asynchronous reset between edges with a live instruction on the inputs
    rst_n = 1'b1;
    driveAll(1'b0, 1'b0, 1'b1, 8'hA5, 96'h1234);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 checkAllReset("reset");
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;

    // DEPTH=1 vector table
    vecs[0] = '{1'b0, 1'b0, 1'b1, 8'h12, 96'h1, 1'b1, 8'h12, 96'h1, 1};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 8'h34, 96'h2, 1'b1, 8'h12, 96'h1, 1};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 8'hFF, 96'h3, 1'b0, 8'h00, 96'h0, 0};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 8'h56, 96'h4, 1'b1, 8'h56, 96'h4, 1};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 8'h77, 96'h5, 1'b0, 8'h00, 96'h0, 0};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 8'h77, 96'h6, 1'b0, 8'h00, 96'h0, 0};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 8'h9A, 96'h7, 1'b1, 8'h9A, 96'h7, 1};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 8'hFF, 96'h8, 1'b1, 8'h9A, 96'h7, 1};
    vecs[8] = '{1'b0, 1'b0, 1'b1, 8'hBC, 96'h9, 1'b1, 8'hBC, 96'h9, 1};
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].s, vecs[i].f, vecs[i].iv, vecs[i].ic, vecs[i].id);
      readDut(1, v, c, dt, o);
      check($sformatf("vec%0d valid", i), 96'(v), 96'(vecs[i].ev));
      check($sformatf("vec%0d ctrl", i), 96'(c), 96'(vecs[i].ec));
      check($sformatf("vec%0d occ", i), 96'(o), 96'(vecs[i].eo));
      if (vecs[i].ev) check($sformatf("vec%0d data", i), dt, vecs[i].ed);
      checkOutput("table");
    end

    // Latency through three stages
    cycle("lat", 1'b0, 1'b1, 1'b0, 8'h00, 96'h0);
    cycle("lat", 1'b0, 1'b0, 1'b1, 8'h3C, 96'hDEAD);
    readDut(3, v, c, dt, o);
    check("lat e0 valid", 96'(v), 96'h0);
    check("lat e0 occ", 96'(o), 96'h1);
    cycle("lat", 1'b0, 1'b0, 1'b0, 8'h00, 96'h0);
    readDut(3, v, c, dt, o);
    check("lat e1 valid", 96'(v), 96'h0);
    check("lat e1 occ", 96'(o), 96'h1);
    cycle("lat", 1'b0, 1'b0, 1'b0, 8'h00, 96'h0);
    readDut(3, v, c, dt, o);
    check("lat e2 valid", 96'(v), 96'h1);
    check("lat e2 ctrl", 96'(c), 96'h3C);
    check("lat e2 data", dt, 96'hDEAD);
    check("lat e2 occ", 96'(o), 96'h1);
    cycle("lat", 1'b0, 1'b0, 1'b0, 8'h00, 96'h0);
    readDut(3, v, c, dt, o);
    check("lat e3 valid", 96'(v), 96'h0);
    check("lat e3 occ", 96'(o), 96'h0);

    // Long stall on a full DEPTH=2 register while inputs keep changing
    cycle("stall", 1'b0, 1'b1, 1'b0, 8'h00, 96'h0);
    cycle("stall", 1'b0, 1'b0, 1'b1, 8'h22, 96'h22);
    cycle("stall", 1'b0, 1'b0, 1'b1, 8'h11, 96'h11);
    for (int j = 0; j < 5; j++) begin
      cycle("stall", 1'b1, 1'b0, 1'b1, j[0] ? 8'hAA : 8'h55, 96'(j));
      readDut(2, v, c, dt, o);
      check("stall hold ctrl", 96'(c), 96'h22);
      check("stall hold occ", 96'(o), 96'h2);
    end
    cycle("stall", 1'b0, 1'b0, 1'b0, 8'h00, 96'h0);
    readDut(2, v, c, dt, o);
    check("stall release ctrl", 96'(c), 96'h11);

    // Flush and stall together on a full DEPTH=2 register
    cycle("flush", 1'b0, 1'b0, 1'b1, 8'h33, 96'h33);
    cycle("flush", 1'b0, 1'b0, 1'b1, 8'h44, 96'h44);
    cycle("flush", 1'b1, 1'b1, 1'b1, 8'hEE, 96'hEE);
    readDut(2, v, c, dt, o);
    check("flush occ", 96'(o), 96'h0);
    check("flush valid", 96'(v), 96'h0);
    check("flush ctrl", 96'(c), 96'h0);
    for (int j = 0; j < 2; j++) begin
      cycle("flush", 1'b0, 1'b0, 1'b0, 8'h00, 96'h0);
      readDut(2, v, c, dt, o);
      check("flush discarded input", 96'(v), 96'h0);
    end

    // A bubble with all control bits set must come out as NOP
    cycle("bubble", 1'b0, 1'b0, 1'b1, 8'h01, 96'h1);
    cycle("bubble", 1'b0, 1'b0, 1'b0, 8'hFF, 96'hF);
    readDut(4, v, c, dt, o);
    check("bubble entry occ", 96'(o), 96'h1);
    cycle("bubble", 1'b0, 1'b0, 1'b0, 8'hFF, 96'hF);
    cycle("bubble", 1'b0, 1'b0, 1'b0, 8'hFF, 96'hF);
    readDut(4, v, c, dt, o);
    check("bubble prior valid", 96'(c), 96'h01);
    cycle("bubble", 1'b0, 1'b0, 1'b0, 8'hFF, 96'hF);
    readDut(4, v, c, dt, o);
    check("bubble out valid", 96'(v), 96'h0);
    check("bubble out ctrl", 96'(c), 96'h0);
    check("bubble out occ", 96'(o), 96'h0);

    // Ten back-to-back instructions through four stages
    cycle("stream", 1'b0, 1'b1, 1'b0, 8'h00, 96'h0);
    nextExp = 1;
    for (int i = 1; i <= 14; i++) begin
      cycle("stream", 1'b0, 1'b0, (i <= 10), 8'(i), 96'(i));
      readDut(4, v, c, dt, o);
      if (i <= 10) check("stream occ", 96'(o), 96'((i < 4) ? i : 4));
      check("stream occ bound", 96'((o <= 4) ? 1 : 0), 96'h1);
      if (i == 4) check("stream first out", 96'(v), 96'h1);
      if (v) begin
        check("stream order ctrl", 96'(c), 96'(nextExp));
        check("stream order data", dt, 96'(nextExp));
        nextExp++;
      end
    end
    check("stream count", 96'(nextExp), 96'd11);

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      cycle("rand", ($urandom_range(3) == 0), ($urandom_range(11) == 0),
            ($urandom_range(9) < 7), 8'($urandom), {$urandom, $urandom, $urandom});
    end

    // Reset arriving mid-stall with full pipelines
    for (int i = 0; i < 4; i++) cycle("midrst", 1'b0, 1'b0, 1'b1, 8'hC0 + 8'(i), 96'(i));
    driveAll(1'b1, 1'b0, 1'b1, 8'h5A, 96'h5A);
    #3 rst_n = 1'b0;
    #1 checkAllReset("midrst");
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle("postrst", 1'b0, 1'b0, 1'b1, 8'h77, 96'h77);
    cycle("postrst", 1'b0, 1'b0, 1'b0, 8'h00, 96'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
